// File: rtl/test_sequencer.sv
// Test-run controller for the SAP-1.5 core: hold CPU in reset, fill a RAM range,
// then release the CPU and count cycles until halt or timeout.
module test_sequencer #(
  parameter int unsigned            ADDR_WIDTH   = 5,
  parameter int unsigned            DATA_WIDTH   = 8,
  parameter int unsigned            RAM_DEPTH    = 16,
  parameter int unsigned            RESET_CYCLES = 2,
  parameter int unsigned            CNT_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0]  FILL_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] clr_start_addr,
  input  logic [ADDR_WIDTH-1:0] clr_end_addr,
  input  logic [CNT_WIDTH-1:0]  max_cycles,
  input  logic                  halt_in,
  output logic                  cpu_reset,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  addr_err,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int unsigned RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]       RC_LAST   = RC_W'(RESET_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  state;
  logic [RC_W-1:0]         rcnt;
  logic [ADDR_WIDTH:0]     caddr;     // one spare bit so the top address cannot wrap
  logic [ADDR_WIDTH-1:0]   end_addr;
  logic [CNT_WIDTH-1:0]    max_cyc;

  logic in_range;
  logic past_end;
  logic at_end;

  assign in_range = caddr < DEPTH_LIM;
  assign past_end = caddr > {1'b0, end_addr};
  assign at_end   = caddr == {1'b0, end_addr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rcnt        <= '0;
      caddr       <= '0;
      end_addr    <= '0;
      max_cyc     <= '0;
      cpu_reset   <= 1'b1;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= FILL_VALUE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      addr_err    <= 1'b0;
      cycle_count <= '0;
    end else begin
      ram_wdata <= FILL_VALUE;
      case (state)
        S_IDLE, S_DONE: begin
          // A new run is accepted from either idle or a finished run
          if (start) begin
            state       <= S_RESET;
            rcnt        <= '0;
            caddr       <= {1'b0, clr_start_addr};
            end_addr    <= clr_end_addr;
            max_cyc     <= max_cycles;
            cpu_reset   <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            addr_err    <= 1'b0;
            cycle_count <= '0;
          end else if (state == S_IDLE) begin
            cpu_reset <= 1'b1;
          end
        end

        S_RESET: begin
          if (rcnt == RC_LAST) begin
            state <= S_CLEAR;
          end else begin
            rcnt <= rcnt + RC_W'(1);
          end
        end

        S_CLEAR: begin
          if (past_end) begin
            // Empty range: no writes, straight on to the run
            ram_we    <= 1'b0;
            state     <= S_RUN;
            cpu_reset <= 1'b0;
          end else begin
            ram_addr <= caddr[ADDR_WIDTH-1:0];
            ram_we   <= in_range;
            if (!in_range) begin
              addr_err <= 1'b1;
            end
            caddr <= caddr + (ADDR_WIDTH + 1)'(1);
            if (at_end) begin
              state     <= S_RUN;
              cpu_reset <= 1'b0;
            end
          end
        end

        S_RUN: begin
          ram_we <= 1'b0;
          // Halt takes priority over the timeout budget
          if (halt_in) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b0;
          end else if (cycle_count == max_cyc) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            cycle_count <= cycle_count + CNT_WIDTH'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
